icnd_read_arbiter: RTL and testbench

ICND_READ_ARBITER -- requirements
Module: icnd_read_arbiter

---
 rtl/icnd_fb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/icnd_read_arbiter.sv | 122 ++++++++++++
 tb/tb_icnd_read_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/icnd_fb_pkg.sv
// Shared definitions for the icnd frame-buffer blocks: data width, channel id
// type and the round-robin pointer advance helper.
package icnd_fb_pkg;

  localparam int DATA_W  = 16;
  localparam int CH_ID_W = 4;

  typedef logic [CH_ID_W-1:0] ch_id_t;

  // Pointer moves to the channel after the one just served, wrapping at n.
  function automatic ch_id_t next_ptr(input ch_id_t g, input int n);
    if (int'(g) >= n - 1) return '0;
    return ch_id_t'(int'(g) + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// returned as a one-hot grant plus a valid flag.
module rr_arbiter
  import icnd_fb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  ch_id_t       ptr,
  output logic [N-1:0] grant,
  output logic         valid
);

  int idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/icnd_read_arbiter.sv
// Shares one frame-buffer memory port between upstream writes and CHANNELS
// round-robin readers. ICND_FB_DOUBLE_BUFFER_EN enables front/back bank swapping.
module icnd_read_arbiter
  import icnd_fb_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int ADDR_W      = 12,
  parameter int MEM_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS-1:0]        ch_read_request,
  input  logic [CHANNELS*ADDR_W-1:0] ch_read_address,
  output logic [DATA_W-1:0]          ch_read_data,
  output logic [CHANNELS-1:0]        ch_read_finished_strobe,
  input  logic                       wr_strobe,
  input  logic [ADDR_W-1:0]          wr_address,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       swap_request,
  output logic                       bank_front,
  output logic [ADDR_W:0]            mem_addr,
  output logic                       mem_wren,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata
);

  logic [CHANNELS-1:0]    outstanding;
  logic [CHANNELS-1:0]    eligible;
  logic [CHANNELS-1:0]    grant_oh;
  logic [CHANNELS-1:0]    strobe_vec;
  logic                   arb_valid;
  logic                   do_grant;
  logic                   write_bank;
  ch_id_t                 ptr;
  ch_id_t                 grant_id;
  logic [ADDR_W-1:0]      grant_addr;
  logic [MEM_LATENCY-1:0] pipe_valid;
  ch_id_t                 pipe_id [MEM_LATENCY];
  logic [DATA_W-1:0]      data_hold;

  assign eligible = ch_read_request & ~outstanding;

  rr_arbiter #(.N(CHANNELS)) u_rr (
    .req   (eligible),
    .ptr   (ptr),
    .grant (grant_oh),
    .valid (arb_valid)
  );

  // A write always wins the port; the pending read simply waits a cycle.
  assign do_grant = arb_valid & ~wr_strobe & ~rst;

  always_comb begin
    grant_id   = '0;
    grant_addr = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (grant_oh[c]) begin
        grant_id   = ch_id_t'(c);
        grant_addr = ch_read_address[c*ADDR_W +: ADDR_W];
      end
    end
  end

`ifdef ICND_FB_DOUBLE_BUFFER_EN
  always_ff @(posedge clk) begin
    if (rst) bank_front <= 1'b0;
    else if (swap_request) bank_front <= ~bank_front;
  end
  assign write_bank = ~bank_front;
`else
  logic unused_swap;
  assign unused_swap = swap_request;
  assign bank_front  = 1'b0;
  assign write_bank  = 1'b0;
`endif

  always_comb begin
    mem_wren  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (wr_strobe) begin
        mem_wren  = 1'b1;
        mem_addr  = {write_bank, wr_address};
        mem_wdata = wr_data;
      end else if (do_grant) begin
        mem_addr = {bank_front, grant_addr};
      end
    end
  end

  always_comb begin
    strobe_vec = '0;
    for (int c = 0; c < CHANNELS; c++)
      strobe_vec[c] = pipe_valid[MEM_LATENCY-1] && (int'(pipe_id[MEM_LATENCY-1]) == c);
  end

  assign ch_read_finished_strobe = strobe_vec;
  assign ch_read_data = pipe_valid[MEM_LATENCY-1] ? mem_rdata : data_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      outstanding <= '0;
      pipe_valid  <= '0;
      data_hold   <= '0;
    end else begin
      if (do_grant) ptr <= next_ptr(grant_id, CHANNELS);
      outstanding   <= (outstanding & ~strobe_vec) | (do_grant ? grant_oh : '0);
      pipe_valid[0] <= do_grant;
      for (int k = 1; k < MEM_LATENCY; k++) pipe_valid[k] <= pipe_valid[k-1];
      if (pipe_valid[MEM_LATENCY-1]) data_hold <= mem_rdata;
    end
  end

  // Channel ids only matter alongside a valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    pipe_id[0] <= grant_id;
    for (int k = 1; k < MEM_LATENCY; k++) pipe_id[k] <= pipe_id[k-1];
  end

endmodule

// File: tb/tb_icnd_read_arbiter.sv
// Directed self-checking bench for icnd_read_arbiter with a latency-2 memory
// model; bank expectations follow ICND_FB_DOUBLE_BUFFER_EN.
module tb_icnd_read_arbiter;

  localparam int CH  = 4;
  localparam int AW  = 12;
  localparam int LAT = 2;
`ifdef ICND_FB_DOUBLE_BUFFER_EN
  localparam logic DB = 1'b1;
`else
  localparam logic DB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] ch_read_request;
  logic [CH*AW-1:0] ch_read_address;
  logic [15:0]   ch_read_data;
  logic [CH-1:0] ch_read_finished_strobe;
  logic          wr_strobe;
  logic [AW-1:0] wr_address;
  logic [15:0]   wr_data;
  logic          swap_request;
  logic          bank_front;
  logic [AW:0]   mem_addr;
  logic          mem_wren;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  icnd_read_arbiter #(.CHANNELS(CH), .ADDR_W(AW), .MEM_LATENCY(LAT)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .ch_read_request         (ch_read_request),
    .ch_read_address         (ch_read_address),
    .ch_read_data            (ch_read_data),
    .ch_read_finished_strobe (ch_read_finished_strobe),
    .wr_strobe               (wr_strobe),
    .wr_address              (wr_address),
    .wr_data                 (wr_data),
    .swap_request            (swap_request),
    .bank_front              (bank_front),
    .mem_addr                (mem_addr),
    .mem_wren                (mem_wren),
    .mem_wdata               (mem_wdata),
    .mem_rdata               (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: word i preloaded with i ^ 16'hC3A5, data LAT cycles after address.
  logic [15:0] mem [0:8191];
  logic [AW:0] rd_q [LAT];

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'(i) ^ 16'hC3A5;
    for (int k = 0; k < LAT; k++) rd_q[k] = '0;
  end

  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr] <= mem_wdata;
    rd_q[0] <= mem_addr;
    for (int k = 1; k < LAT; k++) rd_q[k] <= rd_q[k-1];
  end

  assign mem_rdata = mem[rd_q[LAT-1]];

  function automatic logic [15:0] expVal(input logic [12:0] a);
    return 16'(a) ^ 16'hC3A5;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [CH-1:0] req, input logic wr, input logic [AW-1:0] waddr,
                               input logic [15:0] wdata, input logic swap, input logic r);
    @(negedge clk);
    ch_read_request = req;
    wr_strobe       = wr;
    wr_address      = waddr;
    wr_data         = wdata;
    swap_request    = swap;
    rst             = r;
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_strobe"}, 32'(ch_read_finished_strobe), 32'h0);
    checkOutput({tag, "_data"},   32'(ch_read_data), 32'h0);
    checkOutput({tag, "_bank"},   32'(bank_front), 32'h0);
    checkOutput({tag, "_wren"},   32'(mem_wren), 32'h0);
    checkOutput({tag, "_addr"},   32'(mem_addr), 32'h0);
    checkOutput({tag, "_wdata"},  32'(mem_wdata), 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    ch_read_request = '0;
    wr_strobe = 1'b0;
    wr_address = '0;
    wr_data = '0;
    swap_request = 1'b0;
    ch_read_address = {12'h103, 12'h102, 12'h101, 12'h005};

    // Reset state
    applyStimulus(4'b0000, 1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, '0, '0, 1'b0, 1'b1);
    checkIdle("reset");

    // Single channel 0 read of 0x005
    applyStimulus(4'b0001, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("single_addr", 32'(mem_addr), 32'h005);
    checkOutput("single_wren", 32'(mem_wren), 32'h0);
    checkOutput("single_strobe_t0", 32'(ch_read_finished_strobe), 32'h0);
    applyStimulus(4'b0000, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("single_strobe_t1", 32'(ch_read_finished_strobe), 32'h0);
    applyStimulus(4'b0000, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("single_strobe_t2", 32'(ch_read_finished_strobe), 32'h1);
    checkOutput("single_data_t2", 32'(ch_read_data), 32'hC3A0);
    applyStimulus(4'b0000, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("single_strobe_t3", 32'(ch_read_finished_strobe), 32'h0);
    checkOutput("single_data_hold", 32'(ch_read_data), 32'hC3A0);

    // All four channels continuously: grants 0,1,2,3,0,... one per cycle
    applyStimulus(4'b0000, 1'b0, '0, '0, 1'b0, 1'b1);
    ch_read_address = {12'h103, 12'h102, 12'h101, 12'h100};
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'b1111, 1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput($sformatf("rr_addr_%0d", c), 32'(mem_addr), 32'h100 + 32'(c % 4));
      if (c >= 2) begin
        checkOutput($sformatf("rr_strobe_%0d", c), 32'(ch_read_finished_strobe), 32'h1 << ((c - 2) % 4));
        checkOutput($sformatf("rr_data_%0d", c), 32'(ch_read_data), 32'(expVal(13'h100 + 13'((c - 2) % 4))));
      end else begin
        checkOutput($sformatf("rr_strobe_%0d", c), 32'(ch_read_finished_strobe), 32'h0);
      end
    end

    // Writes block grants for five cycles; pointer (at 2) is kept
    applyStimulus(4'b0000, 1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(4'b0010, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("wb_first_grant", 32'(mem_addr), 32'h101);
    applyStimulus(4'b0000, 1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("wb_first_strobe", 32'(ch_read_finished_strobe), 32'h2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 1'b1, 12'h020 + 12'(i), 16'h1110 + 16'(i), 1'b0, 1'b0);
      checkOutput($sformatf("wb_wren_%0d", i), 32'(mem_wren), 32'h1);
      checkOutput($sformatf("wb_addr_%0d", i), 32'(mem_addr), (DB ? 32'h1000 : 32'h0) + 32'h020 + 32'(i));
      checkOutput($sformatf("wb_wdata_%0d", i), 32'(mem_wdata), 32'h1110 + 32'(i));
      checkOutput($sformatf("wb_strobe_%0d", i), 32'(ch_read_finished_strobe), 32'h0);
    end
    applyStimulus(4'b1111, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("wb_resume_wren", 32'(mem_wren), 32'h0);
    checkOutput("wb_resume_addr", 32'(mem_addr), 32'h102);
    applyStimulus(4'b0000, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("wb_resume_strobe_t1", 32'(ch_read_finished_strobe), 32'h0);
    applyStimulus(4'b0000, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("wb_resume_strobe_t2", 32'(ch_read_finished_strobe), 32'h4);
    checkOutput("wb_resume_data", 32'(ch_read_data), 32'(expVal(13'h102)));

    // Write 0xABCD to 0x010 in the back bank, swap, read it back on channel 1
    applyStimulus(4'b0000, 1'b1, 12'h010, 16'hABCD, 1'b0, 1'b0);
    checkOutput("db_write_addr", 32'(mem_addr), DB ? 32'h1010 : 32'h010);
    checkOutput("db_write_data", 32'(mem_wdata), 32'hABCD);
    applyStimulus(4'b0000, 1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("db_bank_before", 32'(bank_front), 32'h0);
    ch_read_address = {12'h103, 12'h102, 12'h010, 12'h100};
    applyStimulus(4'b0010, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("db_bank_after", 32'(bank_front), 32'(DB));
    checkOutput("db_read_addr", 32'(mem_addr), DB ? 32'h1010 : 32'h010);
    applyStimulus(4'b0000, 1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("db_strobe", 32'(ch_read_finished_strobe), 32'h2);
    checkOutput("db_data", 32'(ch_read_data), 32'hABCD);

    // Reset one cycle after a grant discards the in-flight read
    applyStimulus(4'b1000, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("rst_grant_addr", 32'(mem_addr), DB ? 32'h1103 : 32'h103);
    applyStimulus(4'b1111, 1'b1, 12'h055, 16'h5555, 1'b1, 1'b1);
    checkOutput("rst_ignore_wren", 32'(mem_wren), 32'h0);
    checkOutput("rst_ignore_addr", 32'(mem_addr), 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0000, 1'b0, '0, '0, 1'b0, 1'b0);
      checkIdle($sformatf("post_rst_%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
